// File: rtl/rf_arb_pkg.sv
// Shared definitions for the register-file write-port arbiter.
// Optional build macro RF_ARB_STALL_CNT_EN is consumed by rf_write_arbiter.
package rf_arb_pkg;

  // Two-state controller: clearing sweep, then round-robin arbitration.
  typedef enum logic {
    ST_INIT = 1'b0,
    ST_ARB  = 1'b1
  } arb_state_e;

  localparam int RF_AW       = 5;
  localparam int RF_DW       = 32;
  localparam int RF_NREGS    = 32;
  localparam int STALL_CNT_W = 16;

  // Requester index width; wide enough for the largest supported NREQ (8).
  localparam int IDX_W       = 3;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: grants the first asserted request at or
// after ptr_i, wrapping to the lowest index. Usable by any arbiter that keeps
// its own rotating pointer.
module rr_picker
  import rf_arb_pkg::*;
#(
  parameter int NREQ = 3
) (
  input  logic [NREQ-1:0]  req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [NREQ-1:0]  grant_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  logic [NREQ-1:0] upper_mask;
  logic [NREQ-1:0] upper_req;
  logic [NREQ-1:0] pool;

  // Requests at or above the pointer win; if none, wrap to the full vector.
  assign upper_mask = {NREQ{1'b1}} << ptr_i;
  assign upper_req  = req_i & upper_mask;
  assign pool       = (|upper_req) ? upper_req : req_i;
  // Isolate the lowest set bit of the chosen pool.
  assign grant_o    = pool & (~pool + NREQ'(1));
  assign any_o      = |req_i;

  // Encode the one-hot grant into a binary index.
  always_comb begin
    idx_o = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_o[i]) idx_o = IDX_W'(i);
    end
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter. After reset it sweeps zeros into
// registers 1..NREGS-1, then shares the single write port round-robin among
// NREQ requesters with a registered write interface (accept in cycle N,
// write pulse in cycle N+1). Writes addressed to register 0 are accepted but
// dropped.
// Handshake: a request is accepted in the cycle req_valid[i] & req_ready[i];
// requesters hold valid/addr/data stable until then; req_ready is
// combinational and one-hot.
// Optional build macro RF_ARB_STALL_CNT_EN adds per-requester saturating
// stall counters on output stall_cnt.
module rf_write_arbiter
  import rf_arb_pkg::*;
#(
  parameter int NREQ  = 3,
  parameter int AW    = RF_AW,
  parameter int DW    = RF_DW,
  parameter int NREGS = RF_NREGS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ*DW-1:0]   req_data,
  output logic [NREQ-1:0]      req_ready,
  output logic                 rf_we,
  output logic [AW-1:0]        rf_wa,
  output logic [DW-1:0]        rf_wd,
  output logic [2:0]           grant_id,
  output logic                 init_busy
`ifdef RF_ARB_STALL_CNT_EN
  ,
  output logic [NREQ*STALL_CNT_W-1:0] stall_cnt
`endif
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(NREGS - 1);

  arb_state_e       state_q;
  logic [AW-1:0]    sweep_q;
  logic [IDX_W-1:0] rr_q;
  logic [IDX_W-1:0] rr_d;
  logic             we_q;
  logic [AW-1:0]    wa_q;
  logic [DW-1:0]    wd_q;
  logic [IDX_W-1:0] gid_q;

  logic [NREQ-1:0]  grant;
  logic [IDX_W-1:0] win_idx;
  logic             any_req;
  logic [AW-1:0]    sel_addr;
  logic [DW-1:0]    sel_data;

  rr_picker #(
    .NREQ (NREQ)
  ) u_picker (
    .req_i   (req_valid),
    .ptr_i   (rr_q),
    .grant_o (grant),
    .idx_o   (win_idx),
    .any_o   (any_req)
  );

  // Grants are suppressed during reset and during the clearing sweep.
  assign req_ready = (rst || state_q == ST_INIT) ? '0 : grant;

  // Pointer moves to the requester just after the winner.
  assign rr_d = (win_idx == IDX_W'(NREQ - 1)) ? '0 : win_idx + IDX_W'(1);

  // One-hot AND-OR mux of the winning requester's address and data.
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      sel_addr = sel_addr | ({AW{grant[i]}} & req_addr[i*AW +: AW]);
      sel_data = sel_data | ({DW{grant[i]}} & req_data[i*DW +: DW]);
    end
  end

  // Controller FSM with registered write-port outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_INIT;
      sweep_q <= AW'(1);
      rr_q    <= '0;
      we_q    <= 1'b0;
      wa_q    <= '0;
      wd_q    <= '0;
      gid_q   <= '0;
    end else if (state_q == ST_INIT) begin
      we_q    <= 1'b1;
      wa_q    <= sweep_q;
      wd_q    <= '0;
      sweep_q <= sweep_q + AW'(1);
      if (sweep_q == LAST_ADDR) state_q <= ST_ARB;
    end else begin
      if (any_req) begin
        // Register 0 is hardwired; accept the request but drop the write.
        we_q  <= (sel_addr != '0);
        wa_q  <= sel_addr;
        wd_q  <= sel_data;
        gid_q <= win_idx;
        rr_q  <= rr_d;
      end else begin
        we_q  <= 1'b0;
      end
    end
  end

  assign rf_we     = we_q;
  assign rf_wa     = wa_q;
  assign rf_wd     = wd_q;
  assign grant_id  = gid_q;
  assign init_busy = (state_q == ST_INIT);

`ifdef RF_ARB_STALL_CNT_EN
  for (genvar g = 0; g < NREQ; g++) begin : g_stall
    logic [STALL_CNT_W-1:0] cnt_q;
    // Count cycles requester g waits without a grant, saturating at all-ones.
    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_q <= '0;
      end else if (req_valid[g] && !req_ready[g] && cnt_q != '1) begin
        cnt_q <= cnt_q + STALL_CNT_W'(1);
      end
    end
    assign stall_cnt[g*STALL_CNT_W +: STALL_CNT_W] = cnt_q;
  end
`endif

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Testbench for rf_write_arbiter: directed scenarios followed by randomized
// traffic, checked against a cycle-level reference model of the write port.
module tb_rf_write_arbiter;

  localparam int NREQ  = 3;
  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int NREGS = 32;
  localparam int EW    = 2 + 3 + AW + DW;

  logic                 clk;
  logic                 rst;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ*AW-1:0]   req_addr;
  logic [NREQ*DW-1:0]   req_data;
  logic [NREQ-1:0]      req_ready;
  logic                 rf_we;
  logic [AW-1:0]        rf_wa;
  logic [DW-1:0]        rf_wd;
  logic [2:0]           grant_id;
  logic                 init_busy;
`ifdef RF_ARB_STALL_CNT_EN
  logic [NREQ*16-1:0]   stall_cnt;
`endif

  rf_write_arbiter #(
    .NREQ (NREQ), .AW (AW), .DW (DW), .NREGS (NREGS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_ready (req_ready),
    .rf_we     (rf_we),
    .rf_wa     (rf_wa),
    .rf_wd     (rf_wd),
    .grant_id  (grant_id),
    .init_busy (init_busy)
`ifdef RF_ARB_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  // Entry: {init_busy, rf_we, grant_id, rf_wa, rf_wd} expected next cycle.
  logic [EW-1:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  // Requester-side pending requests (held until accepted).
  logic          p_valid [NREQ];
  logic [AW-1:0] p_addr  [NREQ];
  logic [DW-1:0] p_data  [NREQ];

  // Reference model of the write port.
  bit            m_init;
  int            m_sweep;
  int            m_rr;
  logic [2:0]    m_gid;
  logic          m_we;
  logic [AW-1:0] m_wa;
  logic [DW-1:0] m_wd;
  int            m_stall [NREQ];
  bit            started = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver: one cycle of stimulus + model ----------------
  task automatic step(input logic rst_v);
    logic [NREQ-1:0] vld;
    logic [NREQ-1:0] exp_ready;
    int w;
    @(posedge clk);
    #4;
    for (int i = 0; i < NREQ; i++) begin
      vld[i] = p_valid[i];
      req_addr[i*AW +: AW] = p_addr[i];
      req_data[i*DW +: DW] = p_data[i];
    end
    req_valid = vld;
    rst = rst_v;
    #1;
`ifdef RF_ARB_STALL_CNT_EN
    if (started) begin
      for (int i = 0; i < NREQ; i++)
        chk($sformatf("stall_cnt[%0d]", i), 64'(stall_cnt[i*16 +: 16]), 64'(m_stall[i]));
    end
`endif
    exp_ready = '0;
    if (rst_v) begin
      m_init = 1; m_sweep = 1; m_rr = 0; m_gid = 0;
      m_we = 0; m_wa = '0; m_wd = '0;
    end else if (m_init) begin
      m_we = 1; m_wa = m_sweep[AW-1:0]; m_wd = '0;
      if (m_sweep == NREGS - 1) m_init = 0;
      m_sweep++;
    end else begin
      w = -1;
      for (int k = 0; k < NREQ; k++) begin
        int c;
        c = (m_rr + k) % NREQ;
        if (w < 0 && vld[c]) w = c;
      end
      if (w >= 0) begin
        exp_ready[w] = 1'b1;
        m_we  = (p_addr[w] != '0);
        m_wa  = p_addr[w];
        m_wd  = p_data[w];
        m_gid = w[2:0];
        m_rr  = (w + 1) % NREQ;
      end else begin
        m_we = 0;
      end
    end
    chk("req_ready", 64'(req_ready), 64'(exp_ready));
    for (int i = 0; i < NREQ; i++) begin
      if (rst_v) m_stall[i] = 0;
      else if (vld[i] && !exp_ready[i] && m_stall[i] < 65535) m_stall[i]++;
      if (exp_ready[i]) p_valid[i] = 1'b0;
    end
    exp_q.push_back({m_init ? 1'b1 : 1'b0, m_we, m_gid, m_wa, m_wd});
    started = 1;
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic [EW-1:0] e;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("init_busy", 64'(init_busy), 64'(e[EW-1]));
        chk("rf_we", 64'(rf_we), 64'(e[EW-2]));
        chk("grant_id", 64'(grant_id), 64'(e[EW-3 -: 3]));
        if (e[EW-2]) begin
          chk("rf_wa", 64'(rf_wa), 64'(e[DW +: AW]));
          chk("rf_wd", 64'(rf_wd), 64'(e[DW-1:0]));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    req_valid = '0;
    req_addr = '0;
    req_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      p_valid[i] = 1'b1;
      p_addr[i]  = AW'(i + 1);
      p_data[i]  = DW'(i);
      m_stall[i] = 0;
    end

    // Reset with all requesters valid: nothing may be granted.
    step(1'b1);
    step(1'b1);

    // Clearing sweep with all three held valid.
    repeat (NREGS - 1) step(1'b0);

    // All three continuously valid for 6 arbitration cycles, data = id.
    repeat (6) begin
      step(1'b0);
      for (int i = 0; i < NREQ; i++) begin
        if (!p_valid[i]) begin
          p_valid[i] = 1'b1; p_addr[i] = AW'(i + 1); p_data[i] = DW'(i);
        end
      end
    end
    for (int i = 0; i < NREQ; i++) p_valid[i] = 1'b0;
    step(1'b0);

    // Single request from requester 0.
    p_valid[0] = 1'b1; p_addr[0] = 5; p_data[0] = 32'hDEADBEEF;
    step(1'b0);
    step(1'b0);

    // Requester 1 targets register 0: accepted, write dropped.
    p_valid[1] = 1'b1; p_addr[1] = 0; p_data[1] = 32'h1234;
    step(1'b0);
    // Search now starts at requester 2.
    p_valid[0] = 1'b1; p_addr[0] = 9;  p_data[0] = 32'hA0A0A0A0;
    p_valid[2] = 1'b1; p_addr[2] = 10; p_data[2] = 32'hB2B2B2B2;
    step(1'b0);
    step(1'b0);
    step(1'b0);

    // Reset during arbitration with requester 2 valid.
    p_valid[2] = 1'b1; p_addr[2] = 7; p_data[2] = 32'hCAFE0002;
    step(1'b1);
    p_valid[2] = 1'b0;
    repeat (NREGS + 1) step(1'b0);

    // Randomized traffic with occasional reset.
    repeat (400) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!p_valid[i] && $urandom_range(0, 1) == 1) begin
          p_valid[i] = 1'b1;
          p_addr[i]  = AW'($urandom_range(0, NREGS - 1));
          p_data[i]  = $urandom;
        end
      end
      step($urandom_range(0, 199) == 0);
    end

    for (int i = 0; i < NREQ; i++) p_valid[i] = 1'b0;
    step(1'b0);
    step(1'b0);
    @(posedge clk);
    #3;
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
